// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised sequence detector: a clog2, a symbol
// slice macro and the elaboration-time KMP functions that build the
// transition table from the pattern constant.
`ifndef SEQ_DET_PKG_SV
`define SEQ_DET_PKG_SV

// Symbol i of a packed vector of w-bit symbols, counted from the LSB end.
`define SEQ_DET_SYM(vec, w, i) vec[(i)*(w) +: (w)]

package seq_det_pkg;

  // Patterns are passed to the table functions zero-extended to this width.
  localparam int MAX_PAT_W = 256;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Pattern symbol i, where i=0 is the first expected symbol (MSBs).
  function automatic int get_sym(input logic [MAX_PAT_W-1:0] pat,
                                 input int seq_len, input int sym_w,
                                 input int i);
    int v;
    v = 0;
    for (int b = 0; b < sym_w; b++)
      if (pat[(seq_len-1-i)*sym_w + b]) v |= (1 << b);
    return v;
  endfunction

  // Longest proper suffix of prefix k that is also a pattern prefix.
  function automatic int kmp_fail(input logic [MAX_PAT_W-1:0] pat,
                                  input int seq_len, input int sym_w,
                                  input int k);
    bit ok;
    for (int j = k - 1; j >= 1; j--) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++)
        if (get_sym(pat, seq_len, sym_w, i) != get_sym(pat, seq_len, sym_w, k - j + i))
          ok = 1'b0;
      if (ok) return j;
    end
    return 0;
  endfunction

  // Longest pattern prefix that is a suffix of (prefix k followed by symbol c),
  // for k < seq_len.
  function automatic int kmp_next(input logic [MAX_PAT_W-1:0] pat,
                                  input int seq_len, input int sym_w,
                                  input int k, input int c);
    bit ok;
    int pos;
    int s;
    for (int j = k + 1; j >= 1; j--) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        pos = k + 1 - j + i;
        s = (pos == k) ? c : get_sym(pat, seq_len, sym_w, pos);
        if (get_sym(pat, seq_len, sym_w, i) != s) ok = 1'b0;
      end
      if (ok) return j;
    end
    return 0;
  endfunction

endpackage

`endif

// File: rtl/seq_det_fsm.sv
// Prefix-length state machine: st counts matched pattern symbols, a single
// comparator handles the advancing case and an elaboration-built table
// handles every mismatch through the KMP failure chain.
module seq_det_fsm
  import seq_det_pkg::*;
#(
  parameter int                         SYM_W   = 2,
  parameter int                         SEQ_LEN = 4,
  parameter logic [SEQ_LEN*SYM_W-1:0]   PATTERN = 8'b01_01_10_01,
  parameter bit                         OVERLAP = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  // Din is consumed on every edge where Din_vld=1; there is no back-pressure,
  // and while Din_vld=0 Din is ignored completely.
  input  logic             Din_vld,
  input  logic [SYM_W-1:0] Din,
  output logic             Dout_mealy,
  output logic             Dout_moore
);

  localparam int ST_W = clog2(SEQ_LEN + 1);
  localparam int NSYM = 1 << SYM_W;
  localparam int NROW = 1 << ST_W;
  localparam logic [MAX_PAT_W-1:0] PAT_EXT = MAX_PAT_W'(PATTERN);
  // After a full match, continue from the failure state or from scratch.
  localparam int RESTART = OVERLAP ? kmp_fail(PAT_EXT, SEQ_LEN, SYM_W, SEQ_LEN) : 0;
  localparam logic [ST_W-1:0] LAST = ST_W'(SEQ_LEN);

  logic [ST_W-1:0]  st;
  logic [ST_W-1:0]  st_eff;
  logic [ST_W-1:0]  nxt;
  logic             hit;
  logic [SYM_W-1:0] pat_sym [NROW];
  logic [ST_W-1:0]  mis_tbl [NROW][NSYM];

  // Rows are padded to a power of two so st can index without range issues.
  for (genvar k = 0; k < NROW; k++) begin : g_row
    if (k < SEQ_LEN) begin : g_used
      assign pat_sym[k] = `SEQ_DET_SYM(PATTERN, SYM_W, SEQ_LEN-1-k);
      for (genvar c = 0; c < NSYM; c++) begin : g_col
        assign mis_tbl[k][c] = ST_W'(kmp_next(PAT_EXT, SEQ_LEN, SYM_W, k, c));
      end
    end else begin : g_pad
      assign pat_sym[k] = '0;
      for (genvar c = 0; c < NSYM; c++) begin : g_col
        assign mis_tbl[k][c] = '0;
      end
    end
  end

  // Next prefix length: advance on the expected symbol, else follow the table.
  always_comb begin
    st_eff = (st == LAST) ? ST_W'(RESTART) : st;
    hit    = (Din == pat_sym[st_eff]);
    nxt    = hit ? (st_eff + ST_W'(1)) : mis_tbl[st_eff][Din];
  end

  assign Dout_mealy = Din_vld & (nxt == LAST) & Reset;

  // State and Moore flag only move on valid symbols; a stall holds both.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      st         <= '0;
      Dout_moore <= 1'b0;
    end else if (Din_vld) begin
      st         <= nxt;
      Dout_moore <= (nxt == LAST);
    end
  end

endmodule

// File: rtl/seq_det_param.sv
// Top level of the sequence detector: wraps the prefix FSM and keeps a
// saturating count of completed matches with a synchronous clear.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int                         SYM_W   = 2,
  parameter int                         SEQ_LEN = 4,
  parameter logic [SEQ_LEN*SYM_W-1:0]   PATTERN = 8'b01_01_10_01,
  parameter bit                         OVERLAP = 1'b1,
  parameter int                         CNT_W   = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Din_vld,
  input  logic [SYM_W-1:0] Din,
  input  logic             Clr_cnt,
  output logic             Dout_mealy,
  output logic             Dout_moore,
  output logic [CNT_W-1:0] Match_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  seq_det_fsm #(
    .SYM_W   (SYM_W),
    .SEQ_LEN (SEQ_LEN),
    .PATTERN (PATTERN),
    .OVERLAP (OVERLAP)
  ) u_fsm (
    .Clk        (Clk),
    .Reset      (Reset),
    .Din_vld    (Din_vld),
    .Din        (Din),
    .Dout_mealy (Dout_mealy),
    .Dout_moore (Dout_moore)
  );

  // Clear takes priority, but a match in the clearing cycle is still counted.
  always_ff @(posedge Clk) begin
    if (!Reset)
      Match_cnt <= '0;
    else if (Clr_cnt)
      Match_cnt <= CNT_W'(Dout_mealy);
    else if (Dout_mealy && (Match_cnt != CNT_MAX))
      Match_cnt <= Match_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: three instances (overlap, non-overlap, 2-bit
// counter) share one stimulus stream and are checked every cycle against a
// sliding-window model of "last SEQ_LEN symbols equal the pattern".
module tb_seq_det_param;

  localparam int SYM_W   = 2;
  localparam int SEQ_LEN = 4;
  localparam int NCFG    = 3;

  // ---------------- clock / reset ----------------
  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Din_vld = 1'b0;
  logic       Clr_cnt = 1'b0;
  logic [1:0] Din = 2'd0;

  always #5 Clk = ~Clk;

  logic       mealy0, moore0, mealy1, moore1, mealy2, moore2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  seq_det_param u_dut0 (
    .Clk(Clk), .Reset(Reset), .Din_vld(Din_vld), .Din(Din), .Clr_cnt(Clr_cnt),
    .Dout_mealy(mealy0), .Dout_moore(moore0), .Match_cnt(cnt0));

  seq_det_param #(.OVERLAP(1'b0)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .Din_vld(Din_vld), .Din(Din), .Clr_cnt(Clr_cnt),
    .Dout_mealy(mealy1), .Dout_moore(moore1), .Match_cnt(cnt1));

  seq_det_param #(.CNT_W(2)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .Din_vld(Din_vld), .Din(Din), .Clr_cnt(Clr_cnt),
    .Dout_mealy(mealy2), .Dout_moore(moore2), .Match_cnt(cnt2));

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int pat[SEQ_LEN]   = '{1, 1, 2, 1};
  bit cfg_ovl[NCFG]  = '{1'b1, 1'b0, 1'b1};
  int cfg_max[NCFG]  = '{255, 255, 3};
  int win[NCFG][SEQ_LEN-1];
  int wlen[NCFG];
  bit exp_moore[NCFG];
  int exp_cnt[NCFG];
  bit chk_en = 1'b0;

  // A match completes when the previous SEQ_LEN-1 symbols plus d spell the pattern.
  function automatic bit would_match(input int c, input int d);
    if (wlen[c] < SEQ_LEN - 1) return 1'b0;
    for (int i = 0; i < SEQ_LEN - 1; i++)
      if (win[c][i] != pat[i]) return 1'b0;
    return (d == pat[SEQ_LEN-1]);
  endfunction

  always @(posedge Clk) begin
    if (!Reset) begin
      chk_en = 1'b1;
      for (int c = 0; c < NCFG; c++) begin
        wlen[c] = 0;
        exp_moore[c] = 1'b0;
        exp_cnt[c] = 0;
      end
    end else begin
      for (int c = 0; c < NCFG; c++) begin
        bit m;
        m = Din_vld && would_match(c, int'(Din));
        if (Din_vld) begin
          for (int i = 0; i < SEQ_LEN - 2; i++) win[c][i] = win[c][i+1];
          win[c][SEQ_LEN-2] = int'(Din);
          if (wlen[c] < SEQ_LEN - 1) wlen[c]++;
          exp_moore[c] = m;
          if (m && !cfg_ovl[c]) wlen[c] = 0;
        end
        if (Clr_cnt) exp_cnt[c] = m ? 1 : 0;
        else if (m && exp_cnt[c] < cfg_max[c]) exp_cnt[c]++;
      end
    end
  end

  // Compare every instance against the model away from the active edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      check("mealy0", 32'(mealy0), 32'(Reset && Din_vld && would_match(0, int'(Din))));
      check("moore0", 32'(moore0), 32'(exp_moore[0]));
      check("cnt0",   32'(cnt0),   32'(exp_cnt[0]));
      check("mealy1", 32'(mealy1), 32'(Reset && Din_vld && would_match(1, int'(Din))));
      check("moore1", 32'(moore1), 32'(exp_moore[1]));
      check("cnt1",   32'(cnt1),   32'(exp_cnt[1]));
      check("mealy2", 32'(mealy2), 32'(Reset && Din_vld && would_match(2, int'(Din))));
      check("moore2", 32'(moore2), 32'(exp_moore[2]));
      check("cnt2",   32'(cnt2),   32'(exp_cnt[2]));
    end
  end

  // ---------------- driver ----------------
  task automatic send(input bit rst_n, input bit vld, input int d, input bit clr);
    @(posedge Clk);
    #1;
    Reset   = rst_n;
    Din_vld = vld;
    Din     = 2'(d);
    Clr_cnt = clr;
    @(negedge Clk);
  endtask

  int seq_a[7] = '{1, 1, 2, 1, 1, 2, 1};
  int seq_f[5] = '{1, 1, 1, 2, 1};

  initial begin
    // reset state
    send(1'b0, 1'b0, 0, 1'b0);
    send(1'b0, 1'b0, 0, 1'b0);
    check("lit_rst_cnt",   32'(cnt0),   32'd0);
    check("lit_rst_moore", 32'(moore0), 32'd0);
    check("lit_rst_mealy", 32'(mealy0), 32'd0);

    // overlapping vs non-overlapping on 1,1,2,1,1,2,1
    for (int i = 0; i < 7; i++) begin
      send(1'b1, 1'b1, seq_a[i], 1'b0);
      if (i == 3) check("lit_mealy_sym4", 32'(mealy0), 32'd1);
      if (i == 4) check("lit_moore_after4", 32'(moore0), 32'd1);
      if (i == 6) begin
        check("lit_mealy_sym7_ovl", 32'(mealy0), 32'd1);
        check("lit_mealy_sym7_nov", 32'(mealy1), 32'd0);
      end
    end
    send(1'b1, 1'b0, 0, 1'b0);
    check("lit_cnt_ovl", 32'(cnt0), 32'd2);
    check("lit_cnt_nov", 32'(cnt1), 32'd1);

    // failure chain 1,1,1,2,1
    send(1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 1'b1, seq_f[i], 1'b0);
      if (i == 4) check("lit_fail_chain", 32'(mealy0), 32'd1);
    end

    // stall in the middle and after a match
    send(1'b0, 1'b0, 0, 1'b0);
    send(1'b1, 1'b1, 1, 1'b0);
    send(1'b1, 1'b1, 1, 1'b0);
    send(1'b1, 1'b1, 2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 1'b0, 1, 1'b0);
      check("lit_stall_mealy", 32'(mealy0), 32'd0);
    end
    send(1'b1, 1'b1, 1, 1'b0);
    check("lit_stall_final", 32'(mealy0), 32'd1);
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 1'b0, $urandom_range(0, 3), 1'b0);
      check("lit_stall_moore", 32'(moore0), 32'd1);
    end

    // reset at st=3, then with a completing symbol
    send(1'b0, 1'b0, 0, 1'b0);
    send(1'b1, 1'b1, 1, 1'b0);
    send(1'b1, 1'b1, 1, 1'b0);
    send(1'b1, 1'b1, 2, 1'b0);
    send(1'b0, 1'b1, 1, 1'b0);
    check("lit_rst_complete", 32'(mealy0), 32'd0);
    send(1'b1, 1'b1, 1, 1'b0);
    check("lit_rst_cnt0", 32'(cnt0), 32'd0);
    check("lit_rst_no_match", 32'(mealy0), 32'd0);
    send(1'b1, 1'b0, 0, 1'b0);
    check("lit_rst_st1", 32'(u_dut0.u_fsm.st), 32'd1);
    send(1'b1, 1'b1, 1, 1'b0);
    send(1'b1, 1'b1, 2, 1'b0);
    send(1'b1, 1'b1, 1, 1'b0);
    check("lit_rst_then_match", 32'(mealy0), 32'd1);

    // saturation with a 2-bit counter: 1121 then 121 x4 = five overlapping matches
    send(1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) send(1'b1, 1'b1, seq_a[i], 1'b0);
    for (int r = 0; r < 4; r++)
      for (int i = 4; i < 7; i++) send(1'b1, 1'b1, seq_a[i], 1'b0);
    send(1'b1, 1'b0, 0, 1'b0);
    check("lit_sat_cnt2", 32'(cnt2), 32'd3);
    check("lit_sat_cnt0", 32'(cnt0), 32'd5);
    check("lit_sat_cnt1", 32'(cnt1), 32'd3);

    // clear together with a match
    send(1'b1, 1'b1, 1, 1'b0);
    send(1'b1, 1'b1, 2, 1'b0);
    send(1'b1, 1'b1, 1, 1'b1);
    send(1'b1, 1'b0, 0, 1'b0);
    check("lit_clr_match0", 32'(cnt0), 32'd1);
    check("lit_clr_match2", 32'(cnt2), 32'd1);
    check("lit_clr_nomatch1", 32'(cnt1), 32'd0);

    // randomized stream, model-checked every cycle
    send(1'b0, 1'b0, 0, 1'b0);
    for (int n = 0; n < 4000; n++) begin
      int r;
      int d;
      r = $urandom_range(0, 5);
      d = (r < 3) ? 1 : (r < 5) ? 2 : $urandom_range(0, 3);
      send($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, d,
           $urandom_range(0, 63) == 0);
    end
    send(1'b1, 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
